// File: rtl/instruction_cache_controller_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled for port connection.
// The cache uses the slave modport; whatever models the fetch stage and memory uses master.
interface instruction_cache_controller_if;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  modport slave (
    input  address, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address, hit_count, miss_count
  );

  modport master (
    output address, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address, hit_count, miss_count
  );
endinterface

// File: rtl/instruction_cache_controller.sv
// Direct-mapped read-only instruction cache with 16-byte blocks.
// Hits are served combinationally; a miss stalls fetch while one block is refilled.
module instruction_cache_controller #(
  parameter int          INDEX_BITS = 3,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic                            clk,
  input logic                            reset,
  instruction_cache_controller_if.slave  bus
);
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;
  localparam int TAG_BITS   = 28 - INDEX_BITS;
  localparam logic [31:0] SENTINEL_PC = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
  logic [TAG_BITS-1:0]     tag_q  [NUM_BLOCKS];
  logic [127:0]            data_q [NUM_BLOCKS];
  logic [27:0]             miss_addr_q, miss_addr_d;
  logic [127:0]            fill_q, fill_d;
  logic [31:0]             hit_count_q, hit_count_d;
  logic [31:0]             miss_count_q, miss_count_d;

  logic [1:0]              offset;
  logic [INDEX_BITS-1:0]   index;
  logic [INDEX_BITS-1:0]   fill_index;
  logic [TAG_BITS-1:0]     tag;
  logic                    sentinel;
  logic                    hit;
  logic                    write_en;
  logic [31:0]             instruction_c;
  logic                    busywait_c;
  logic                    mem_read_c;
  logic                    unused_addr_bits;

  assign offset           = bus.address[3:2];
  assign index            = bus.address[4 +: INDEX_BITS];
  assign tag              = bus.address[31:4+INDEX_BITS];
  assign sentinel         = (bus.address == SENTINEL_PC);
  assign hit              = valid_q[index] && (tag_q[index] == tag);
  assign fill_index       = miss_addr_q[INDEX_BITS-1:0];
  assign unused_addr_bits = ^bus.address[1:0];

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    miss_addr_d   = miss_addr_q;
    fill_d        = fill_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    write_en      = 1'b0;
    instruction_c = NOP_INSTR;
    busywait_c    = 1'b0;
    mem_read_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sentinel) begin
          if (hit) begin
            instruction_c = data_q[index][{offset, 5'b0} +: 32];
            hit_count_d   = hit_count_q + 32'd1;
          end else begin
            busywait_c   = 1'b1;
            miss_addr_d  = bus.address[31:4];
            miss_count_d = miss_count_q + 32'd1;
            state_d      = MEM_READ;
          end
        end
      end
      MEM_READ: begin
        busywait_c = 1'b1;
        mem_read_c = 1'b1;
        if (!bus.mem_busywait) begin
          fill_d  = bus.mem_readdata;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        // The fetch address may have moved on; the fill always targets the latched block.
        busywait_c          = 1'b1;
        write_en            = 1'b1;
        valid_d[fill_index] = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_addr_q  <= '0;
      fill_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_addr_q  <= miss_addr_d;
      fill_q       <= fill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide a hit.
  always_ff @(posedge clk) begin
    if (write_en) begin
      data_q[fill_index] <= fill_q;
      tag_q[fill_index]  <= miss_addr_q[27:INDEX_BITS];
    end
  end

  assign bus.instruction = instruction_c;
  assign bus.busywait    = busywait_c;
  assign bus.mem_read    = mem_read_c;
  assign bus.mem_address = miss_addr_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.miss_count  = miss_count_q;
endmodule

// File: tb/tb_instruction_cache_controller.sv
// Scoreboard bench for the instruction cache: a fetch-stage driver, a latency-programmable
// memory responder, and a monitor that checks every served fetch against a block-level model.
module tb_instruction_cache_controller;
  localparam logic [31:0] SENT = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    int          hits;
    int          misses;
    int          stalls;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_cache_controller_if bus();

  instruction_cache_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  logic [27:0] blk_q[$];
  bit          m_valid[8];
  int          m_tag[8];
  int          m_hits = 0;
  int          m_misses = 0;
  int          mem_lat = 0;

  // Memory image: each word is derived from its own byte address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h13 + ((a >> 2) * 32'h80);
  endfunction

  function automatic logic [127:0] block_of(input logic [27:0] b);
    logic [31:0] base;
    base = {b, 4'b0000};
    return {word_of(base + 12), word_of(base + 8), word_of(base + 4), word_of(base)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: holds busy for mem_lat edges, then returns the requested block.
  int          lat_cnt = 0;
  logic [27:0] held_blk;
  always @(negedge clk) begin
    if (reset || !bus.mem_read) begin
      lat_cnt          = 0;
      bus.mem_busywait = 1'b1;
      bus.mem_readdata = '0;
    end else begin
      if (lat_cnt == 0) begin
        held_blk = bus.mem_address;
        if (blk_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_refill: got block %0h, expected none", bus.mem_address);
        end else begin
          check("mem_address", bus.mem_address, blk_q.pop_front());
        end
      end else begin
        check("mem_address_stable", bus.mem_address, held_blk);
      end
      if (lat_cnt < mem_lat) begin
        bus.mem_busywait = 1'b1;
      end else begin
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = block_of(bus.mem_address);
      end
      lat_cnt++;
    end
  end

  // Monitor: counts stall cycles and pops one expectation per served fetch.
  int   stall_cnt = 0;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      stall_cnt = 0;
    end else if (bus.address == SENT) begin
      check("sentinel_busywait", bus.busywait, 1'b0);
      check("sentinel_instr", bus.instruction, NOP);
      check("sentinel_mem_read", bus.mem_read, 1'b0);
      check("sentinel_hit_count", bus.hit_count, m_hits);
      check("sentinel_miss_count", bus.miss_count, m_misses);
    end else if (bus.busywait) begin
      stall_cnt++;
    end else begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_serve: got instr %0h, expected no serve", bus.instruction);
      end else begin
        e = sb.pop_front();
        check("instruction", bus.instruction, e.instr);
        check("hit_count", bus.hit_count, e.hits);
        check("miss_count", bus.miss_count, e.misses);
        if (e.stalls >= 0) check("stall_cycles", stall_cnt, e.stalls);
      end
      stall_cnt = 0;
    end
  end

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[6:4]] && (m_tag[a[6:4]] == int'(a[31:7]));
  endfunction

  // Records a fetch in the model; a miss refills the block and queues the refill address.
  function automatic bit model_access(input logic [31:0] a);
    bit h;
    h = model_hit(a);
    if (!h) begin
      m_valid[a[6:4]] = 1'b1;
      m_tag[a[6:4]]   = int'(a[31:7]);
      m_misses++;
      blk_q.push_back(a[31:4]);
    end
    return h;
  endfunction

  task automatic wait_served();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busywait) return;
    end
    vectors++;
    miscompares++;
    $display("[TB] FAIL serve_timeout: got busywait stuck, expected serve within 60 cycles");
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input int lat);
    bit   h;
    exp_t x;
    @(posedge clk);
    #1;
    mem_lat     = lat;
    bus.address = a;
    h           = model_access(a);
    x.instr     = word_of(a);
    x.hits      = m_hits;
    x.misses    = m_misses;
    x.stalls    = h ? 0 : lat + 3;
    sb.push_back(x);
    m_hits++;
    wait_served();
  endtask

  // Moves the fetch address while the refill for a is still in MEM_READ.
  task automatic apply_jump(input logic [31:0] a, input logic [31:0] b, input int lat);
    bit   h;
    exp_t x;
    if (model_hit(a)) begin
      apply_stimulus(b, lat);
      return;
    end
    @(posedge clk);
    #1;
    mem_lat     = lat;
    bus.address = a;
    h           = model_access(a);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    bus.address = b;
    h           = model_access(b);
    x.instr     = word_of(b);
    x.hits      = m_hits;
    x.misses    = m_misses;
    x.stalls    = -1;
    sb.push_back(x);
    m_hits++;
    wait_served();
  endtask

  task automatic apply_sentinel();
    @(posedge clk);
    #1;
    bus.address = SENT;
    @(negedge clk);
  endtask

  task automatic reset_mid_refill(input logic [31:0] a);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    mem_lat     = 3;
    bus.address = a;
    blk_q.push_back(a[31:4]);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_read;
    end
    check("refill_started", seen, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mem_read", bus.mem_read, 1'b0);
    check("reset_busywait_miss", bus.busywait, 1'b1);
    check("reset_hit_count", bus.hit_count, 0);
    check("reset_miss_count", bus.miss_count, 0);
    bus.address = SENT;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    sb.delete();
    blk_q.delete();
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    logic [31:0] a;
    reset       = 1'b1;
    bus.address = SENT;
    #12;
    check("init_mem_read", bus.mem_read, 1'b0);
    check("init_mem_address", bus.mem_address, 28'h0);
    check("init_busywait", bus.busywait, 1'b0);
    check("init_instruction", bus.instruction, NOP);
    check("init_hit_count", bus.hit_count, 0);
    check("init_miss_count", bus.miss_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    apply_stimulus(32'h0000_0000, 3);
    apply_stimulus(32'h0000_0004, 0);
    apply_stimulus(32'h0000_0008, 0);
    apply_stimulus(32'h0000_000C, 0);
    apply_stimulus(32'h0000_0080, 0);
    apply_stimulus(32'h0000_0000, 1);
    apply_jump(32'h0000_0010, 32'h0000_0040, 2);
    apply_stimulus(32'h0000_0014, 0);
    apply_sentinel();

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       apply_sentinel();
        1:       apply_jump(rand_addr(), rand_addr(), int'($urandom_range(1, 3)));
        default: apply_stimulus(rand_addr(), int'($urandom_range(0, 3)));
      endcase
    end

    reset_mid_refill(32'h0000_0F80);
    apply_stimulus(32'h0000_0000, 0);
    apply_stimulus(32'h0000_0004, 0);
    apply_sentinel();

    repeat (3) @(negedge clk);
    a = 32'(sb.size());
    check("scoreboard_drained", a, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_cache_controller.md
Name: instruction_cache_controller

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage PC output and the backing instruction memory.
- On a hit, returns the 32-bit instruction in the same cycle.
- On a miss, drives busywait high (which stalls PC update), refills one 16-byte block from memory, then serves the hit.
- Its busywait output is the instruction_mem_busywait input of the fetch stage.

Parameters:
- INDEX_BITS, 3, log2 of block count (default 8 blocks); tag width = 28 - INDEX_BITS.
- NOP_INSTR, 32'h0000_0013, instruction returned when no valid request is present.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- address  input  32  PC from fetch stage; bits [1:0] ignored
- instruction  output  32  instruction word for address
- busywait  output  1  high while the requested word is not yet available
- mem_read  output  1  read request to instruction memory
- mem_address  output  28  block address to memory (byte address [31:4])
- mem_readdata  input  128  block from memory; word0 in [31:0] ... word3 in [127:96]
- mem_busywait  input  1  memory busy; data valid on the edge where mem_read=1 and mem_busywait=0
- hit_count  output  32  number of hits served
- miss_count  output  32  number of misses (refills started)

Behaviour:
- Address split: offset = address[3:2], index = address[4+INDEX_BITS-1:4], tag = address[31:4+INDEX_BITS].
- Storage per block: valid bit, tag, and 4 x 32-bit words.
- Reset (asynchronous):
  - All valid bits cleared; state = IDLE.
  - mem_read = 0, mem_address = 0, busywait = 0, instruction = NOP_INSTR.
  - hit_count = 0, miss_count = 0.
  - Data and tag arrays need not be cleared.
- Sentinel: address == 32'hFFFF_FFFC is the pre-start PC.
  - Treated as no request: busywait = 0, instruction = NOP_INSTR.
  - No lookup, no counter change.
- States: IDLE, MEM_READ, UPDATE.
- IDLE, hit (valid[index] and tag match):
  - Combinational: instruction = selected word, busywait = 0.
  - hit_count increments once per rising edge on which a hit is presented.
- IDLE, miss (not sentinel):
  - Combinational: busywait = 1, instruction = NOP_INSTR.
  - Next edge: latch address[31:4] into miss register, go to MEM_READ, increment miss_count.
- MEM_READ:
  - mem_read = 1, mem_address = latched block address, busywait = 1.
  - Held until an edge with mem_busywait = 0; on that edge capture mem_readdata and go to UPDATE.
- UPDATE:
  - mem_read = 0, busywait = 1.
  - Next edge: write data, tag and valid into latched index; return to IDLE.
  - Lookup re-evaluates the following cycle.
- Miss penalty with memory latency L edges in MEM_READ: busywait high for L + 2 cycles after the miss cycle.
  - For a zero-wait memory, the hit is served in the 3rd cycle after the miss is presented.
- Address change during a refill (e.g. reset of fetch, jump):
  - The outstanding refill completes for the latched block.
  - The new address is then looked up in IDLE.
  - mem_address never changes while mem_read = 1.
- Replacement: direct-mapped overwrite; no dirty state, no writeback.
- Counters wrap modulo 2^32.
- Reset asserted mid-refill: immediate return to IDLE, mem_read drops asynchronously, the partially fetched block is discarded and no valid bit is set.

Test Plan:
- Reset, then address = FFFF_FFFC -> busywait = 0, instruction = 0000_0013, mem_read = 0, counters 0.
- Address 0000_0000, cold cache, memory returns 128'h...0000_0093_0000_0013 after 3 busy cycles -> busywait high 5 cycles, mem_address = 0, then instruction = 0000_0013, busywait = 0, miss_count = 1.
- Sequential 0x04, 0x08, 0x0C after the fill -> all hits, no mem_read, correct words 1..3, hit_count increments each cycle.
- Conflict: 0x0000_0000 then 0x0000_0080 (same index 0, different tag) then 0x0000_0000 -> three refills, miss_count = 3, each fill overwrites block 0.
- Address changes from 0x10 to 0x40 while in MEM_READ -> mem_address stays 1 until the fill completes; block 1 becomes valid; a new miss for block 4 follows.
- Reset pulsed during MEM_READ -> mem_read = 0 immediately, valid[0] = 0, re-access of 0x00 misses again.
